// File: rtl/daq_sweep_sequencer_if.sv
// DAQ trigger/capture and result-stream signals of the sweep sequencer.
// master is the sequencer side; slave is the DAQ controller and result sink.
interface daq_sweep_sequencer_if #(
    parameter int DW = 12
);
    logic          daq_start_o;
    logic [DW-1:0] daq_dac_in_o;
    logic          daq_done;
    logic [DW-1:0] daq_adc_data;
    logic          res_valid_o;
    logic          res_ready;
    logic [DW-1:0] res_code_o;
    logic [DW-1:0] res_data_o;
    logic          res_last_o;

    modport master (
        output daq_start_o,
        output daq_dac_in_o,
        input  daq_done,
        input  daq_adc_data,
        output res_valid_o,
        input  res_ready,
        output res_code_o,
        output res_data_o,
        output res_last_o
    );

    modport slave (
        input  daq_start_o,
        input  daq_dac_in_o,
        output daq_done,
        output daq_adc_data,
        input  res_valid_o,
        output res_ready,
        input  res_code_o,
        input  res_data_o,
        input  res_last_o
    );
endinterface

// File: rtl/daq_sweep_sequencer.sv
// Multi-point DAC-step / ADC-capture sweep sequencer on top of the DAQ controller.
// Each point: settle, trigger, wait for conversion, hand (code, data) downstream.
module daq_sweep_sequencer #(
    parameter int DW  = 12,
    parameter int NPW = 10,
    parameter int SW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sweep_start,
    input  logic                  abort,
    input  logic [DW-1:0]         code_start,
    input  logic [DW-1:0]         code_step,
    input  logic [NPW-1:0]        num_points,
    input  logic [SW-1:0]         settle_cycles,
    output logic [NPW-1:0]        point_idx_o,
    output logic                  busy_o,
    output logic                  sweep_done_o,
    daq_sweep_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIG,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    state_e         state_q;
    logic [DW-1:0]  step_q;
    logic [NPW-1:0] np_q;
    logic [SW-1:0]  settle_q;
    logic [SW-1:0]  cnt_q;
    logic [NPW-1:0] idx_q;
    logic [DW-1:0]  dac_q;
    logic           daq_start_q;
    logic           res_valid_q;
    logic [DW-1:0]  res_code_q;
    logic [DW-1:0]  res_data_q;
    logic           res_last_q;
    logic           busy_q;
    logic           done_q;

    logic [DW:0]    sum_d;
    logic [DW-1:0]  code_nxt_d;

    // Code stepping saturates at full scale instead of wrapping.
    always_comb begin
        sum_d      = {1'b0, dac_q} + {1'b0, step_q};
        code_nxt_d = sum_d[DW] ? {DW{1'b1}} : sum_d[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            np_q        <= '0;
            settle_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            dac_q       <= '0;
            daq_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_code_q  <= '0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && state_q != S_IDLE) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            daq_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            daq_start_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sweep_start && !abort) begin
                        step_q   <= code_step;
                        np_q     <= num_points;
                        settle_q <= settle_cycles;
                        busy_q   <= 1'b1;
                        if (num_points == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETTLE;
                            idx_q   <= '0;
                            dac_q   <= code_start;
                            cnt_q   <= settle_cycles;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_TRIG;
                        daq_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - SW'(1);
                    end
                end
                S_TRIG: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.daq_done) begin
                        res_data_q  <= bus.daq_adc_data;
                        res_code_q  <= dac_q;
                        res_last_q  <= (idx_q == np_q - NPW'(1));
                        res_valid_q <= 1'b1;
                        state_q     <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (res_last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + NPW'(1);
                            dac_q   <= code_nxt_d;
                            cnt_q   <= settle_q;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign point_idx_o      = idx_q;
    assign busy_o           = busy_q;
    assign sweep_done_o     = done_q;
    assign bus.daq_start_o  = daq_start_q;
    assign bus.daq_dac_in_o = dac_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_code_o   = res_code_q;
    assign bus.res_data_o   = res_data_q;
    assign bus.res_last_o   = res_last_q;

endmodule
